// File: rtl/ofifo.sv
// rtl/ofifo.sv - per-column output FIFO collecting MAC psums into rows; optional sticky o_err under OFIFO_ERR_EN
module ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
`ifdef OFIFO_ERR_EN
    output logic                   o_ready,
    output logic                   o_err
`else
    output logic                   o_ready
`endif
);

    localparam int aw = $clog2(depth);

    logic [col-1:0] col_empty;
    logic [col-1:0] col_full;
    logic [col-1:0] wr_acc;
    logic           pop;

    // A row is only complete once the slowest column has caught up
    assign o_valid = ~|col_empty;
    assign o_full  = |col_full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar g = 0; g < col; g++) begin : g_col
        logic [aw:0]        wptr_q, wptr_d;
        logic [aw:0]        rptr_q, rptr_d;
        logic [psum_bw-1:0] mem_q [depth];

        assign col_empty[g] = (wptr_q == rptr_q);
        assign col_full[g]  = (wptr_q[aw-1:0] == rptr_q[aw-1:0]) && (wptr_q[aw] != rptr_q[aw]);
        // Fullness is judged on registered pointers, so a same-cycle pop never rescues a write
        assign wr_acc[g]    = wr[g] & ~col_full[g];
        assign wptr_d       = wr_acc[g] ? wptr_q + 1'b1 : wptr_q;
        assign rptr_d       = pop ? rptr_q + 1'b1 : rptr_q;

        // Head entry falls through; zeroed while any column is empty so stale storage never leaks
        assign out[g*psum_bw +: psum_bw] = o_valid ? mem_q[rptr_q[aw-1:0]] : '0;

        // Storage is left unreset; only accepted writes land
        always_ff @(posedge clk) begin
            if (!reset && wr_acc[g]) begin
                mem_q[wptr_q[aw-1:0]] <= in[g*psum_bw +: psum_bw];
            end
        end

        // Pointer update; reset discards every buffered entry at once
        always_ff @(posedge clk) begin
            if (reset) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
            end
        end
    end

`ifdef OFIFO_ERR_EN
    logic err_q, err_d;

    assign err_d = err_q | (|(wr & col_full)) | (rd & ~o_valid);
    assign o_err = err_q;

    // Sticky error flag: dropped write or pop of an incomplete row
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: doc/ofifo.md
OFIFO -- requirements
Module: ofifo

Interface
REQ-001 The block SHALL have parameter col, default 8, meaning the number of MAC columns collected.
REQ-002 The block SHALL have parameter psum_bw, default 16, meaning the partial-sum width per column.
REQ-003 The block SHALL have parameter depth, default 8, meaning entries per column FIFO; it is a power of two and at least 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in, input, psum_bw*col bits: per-column psums from the upstream MAC row south outputs; column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-007 Port wr, input, col bits: per-column write strobes, driven by the MAC row valid outputs.
REQ-008 Port rd, input, 1 bit: pop request for one full output row.
REQ-009 Port out, output, psum_bw*col bits: head entry of every column, in the same column packing as in.
REQ-010 Port o_valid, output, 1 bit: every column FIFO is non-empty.
REQ-011 Port o_full, output, 1 bit: at least one column FIFO is full.
REQ-012 Port o_ready, output, 1 bit: no column FIFO is full; always equals ~o_full.

Function
REQ-013 Each column SHALL be an independent circular FIFO with read and write pointers of log2(depth)+1 bits; the MSB is the wrap bit.
REQ-014 Column i SHALL be empty when its pointers are equal, and full when the low bits are equal and the wrap bits differ.
REQ-015 On a rising edge with wr[i]=1 and column i not full, the block SHALL store in's column-i slice at the write pointer and advance that pointer by 1, modulo 2*depth.
REQ-016 A write to a full column SHALL be dropped; no pointer or storage changes, even if a pop occurs in the same cycle.
REQ-017 On a rising edge with rd=1 and o_valid=1, every column read pointer SHALL advance by 1 at once (row pop).
REQ-018 rd=1 with o_valid=0 SHALL be ignored; no column's read pointer moves.
REQ-019 A simultaneous write and pop on the same non-full column SHALL perform both; that column's occupancy is unchanged.
REQ-020 out SHALL be first-word-fall-through: combinationally the head entry of each column while o_valid=1, and all zeros while o_valid=0.
REQ-021 o_valid, o_full and o_ready SHALL be combinational functions of the registered pointers only, and SHALL NOT depend on wr or rd.
REQ-022 Columns SHALL accept writes in any skewed order; a row becomes visible only once the slowest column has written it.
REQ-023 Pointer wrap-around SHALL be seamless; data order across the wrap SHALL be preserved.

Reset
REQ-024 While reset=1 at a rising edge, all pointers SHALL clear to 0 and wr and rd SHALL be ignored.
REQ-025 After reset: o_valid=0, o_full=0, o_ready=1, out=0.
REQ-026 Storage contents SHALL NOT be reset; they are unobservable because out is forced to zero while empty.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries within one cycle.

Configuration
REQ-028 With macro OFIFO_ERR_EN defined, the block SHALL add output o_err, 1 bit, reset 0.
REQ-029 o_err SHALL go to 1 and stay set (sticky) until reset on either event: any dropped write to a full column, or rd=1 while o_valid=0.
REQ-030 Without OFIFO_ERR_EN, the block SHALL have no o_err port and no error logic; all other behaviour is identical.

Verification
REQ-031 Reset, then idle -> o_valid=0, o_full=0, o_ready=1, out=0.
REQ-032 Skewed writes: wr=8'b0000_0001, then 8'b0000_0011, ..., each column's in slice=16'h000A, then stop -> o_valid=0 until column 7 has written; after that edge o_valid=1 and out={8{16'h000A}}; one rd -> o_valid=0.
REQ-033 Fill: wr=8'hFF for 8 cycles with row k=16'h0010+k -> o_full=1, o_ready=0; 9th write dropped; 8 pops return 16'h0010..16'h0017 in order, then o_valid=0 (OFIFO_ERR_EN: o_err=1 after the dropped write).
REQ-034 Wrap: 20 rows written and popped in steady state with 3 entries buffered -> all 20 values read in order; occupancy stays 3.
REQ-035 rd with o_valid=0 -> no pointer change (OFIFO_ERR_EN: o_err=1, cleared only by reset).
REQ-036 Reset asserted with 5 rows buffered -> next cycle o_valid=0, out=0; a new write of 16'h0001 on every column is read back as the next row.
